hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage PCPU. It sits beside the forwarding unit and sequences the pipeline registers: it stalls on load-use hazards and on branch/jump operands the forwarding paths cannot yet supply. It also flushes IF/ID on taken branches and freezes the pipe while a multi-cycle multiply/divide occupies EX. A saturating stall-cycle counter is exposed for performance monitoring.

## Interface
- `MDU_LAT`, default 4: total EX occupancy in cycles of a mul/div op (≥2).
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock. One clock domain; everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `IF_ID_Rs`, `IF_ID_Rt`  in  5 each  source registers of the instruction in ID.
- `UsesRt`  in  1  the ID instruction reads Rt as an ALU operand.
- `PCWriteCond`  in  4  non-zero means the ID instruction is a conditional branch, which reads Rs and Rt.
- `Jump`  in  2  non-zero means the ID instruction is a jump, which reads Rs only.
- `BranchTaken`  in  1  branch/jump resolved taken in ID this cycle.
- `ID_EX_WriteReg`  in  5  destination register in EX.
- `ID_EX_RegWrite`, `ID_EX_MemRead`  in  1 each.
- `EX_MEM_WriteReg`  in  5  destination register in MEM.
- `EX_MEM_MemRead`  in  1.
- `MduStart`  in  1  EX holds a mul/div op.
- `PCWrite`  out  1  PC enable.
- `IF_ID_Write`  out  1  IF/ID enable.
- `IF_ID_Flush`  out  1  zero IF/ID on the next edge.
- `ID_EX_Write`  out  1  ID/EX enable.
- `ID_EX_Bubble`  out  1  load a NOP into ID/EX.
- `EX_MEM_Bubble`  out  1  load a NOP into EX/MEM.
- `StallCount`  out  `CNT_W`  saturating count of cycles with `PCWrite`=0.

## Operation
A register with destination 0 never creates a hazard. A register "matches" if it equals `IF_ID_Rs`, or it equals `IF_ID_Rt` when Rt is read (`UsesRt`, or `PCWriteCond`≠0).

Hazard terms, evaluated in RUN:
- LU: `ID_EX_MemRead` and `ID_EX_WriteReg` matches.
- BEX: the ID instruction is a branch or jump, `ID_EX_RegWrite`, and `ID_EX_WriteReg` matches.
- BMEM: the ID instruction is a branch or jump, `EX_MEM_MemRead`, and `EX_MEM_WriteReg` matches.
- A stall is LU | BEX | BMEM. It drives `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Bubble`=1 and `IF_ID_Flush`=0.

FSM states and transitions:
- RUN, with `MduStart`=1: freeze. `PCWrite`, `IF_ID_Write`, `ID_EX_Write`=0 and `EX_MEM_Bubble`=1. Load the counter with `MDU_LAT`-2 and go to MDU. MDU takes priority over every hazard term.
- RUN, with BEX and `ID_EX_MemRead`: stall and go to BSTALL.
- RUN, otherwise: stall if any hazard term holds. If there is no stall and `BranchTaken`, drive `IF_ID_Flush`=1. Stay in RUN.
- BSTALL: one forced stall, with outputs identical to a stall. Return to RUN.
- MDU: freeze outputs as above. Decrement the counter; when it reaches 0, return to RUN. Total freeze is `MDU_LAT` cycles, counting the entry cycle.
- `StallCount` increments every cycle in which `PCWrite`=0, and holds at all-ones.

## Timing
- Hazard outputs are combinational from the current state and inputs, with no added latency. State and counters update on the clock edge.
- Reset while `rst_n`=0:
  - State is RUN; the MDU counter and `StallCount` are 0.
  - Outputs are forced to `PCWrite`=`IF_ID_Write`=`ID_EX_Write`=1 and `IF_ID_Flush`=`ID_EX_Bubble`=`EX_MEM_Bubble`=0.
  - Reset asserted mid-MDU or mid-BSTALL abandons the sequence immediately.
- During a stall or freeze, `BranchTaken` is ignored; the branch re-resolves once it is released.
- `StallCount` at all-ones with another stall stays at all-ones; it does not wrap.

## Structure
- A shared package `pcpu_pkg` holds the state enum (RUN, BSTALL, MDU) and the NOP encoding constant.
- One sub-module, `sat_counter` (parameter `CNT_W`, inputs `inc` and `rst_n`), implements `StallCount`.

## Test plan
- Load-use: `ID_EX_MemRead`=1, `ID_EX_WriteReg`=5, `IF_ID_Rs`=5.
  - Expect one cycle of `PCWrite`=0 and `ID_EX_Bubble`=1.
  - Then `StallCount`=1.
- Branch after a load: `PCWriteCond`=1, `IF_ID_Rt`=8, `ID_EX_MemRead`=`ID_EX_RegWrite`=1, `ID_EX_WriteReg`=8.
  - Expect two stall cycles (RUN→BSTALL→RUN).
  - Then `StallCount`=2.
- Jump dependency: `Jump`=2, `IF_ID_Rt`=8, `ID_EX_WriteReg`=8, no load.
  - Expect no stall, because a jump reads Rs only.
  - With `IF_ID_Rs`=8 instead, expect a 1-cycle stall.
- Taken branch, no hazard: `BranchTaken`=1.
  - Expect `IF_ID_Flush`=1 for exactly that cycle.
  - Repeat with a simultaneous LU stall: expect `IF_ID_Flush`=0.
- MDU with `MDU_LAT`=4: pulse `MduStart`.
  - Expect exactly 4 cycles of `ID_EX_Write`=0 and `EX_MEM_Bubble`=1, then RUN.
  - Deassert `rst_n` in the 2nd cycle: all outputs return to run values at once and `StallCount`=0.
- Saturation with `CNT_W`=4: hold LU for 20 cycles.
  - `StallCount` reaches 15 and stays there.

Source files
------------

// File: rtl/pcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_pkg
//  Description : Shared definitions for the five-stage PCPU control path.
//                Holds the hazard controller state encoding, the NOP
//                instruction encoding and a register-match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pcpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BSTALL = 2'd1,
    ST_MDU    = 2'd2
  } state_e;

  // All-zero word decodes as sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // A destination creates a dependency only if it is non-zero and equals
  // Rs, or equals Rt when Rt is actually read by the ID instruction.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       rt_read);
    return (dst != 5'd0) && ((dst == rs) || (rt_read && (dst == rt)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset (clears count)
//                inc   - count this cycle
//                count - current value
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the five-stage PCPU.
//                Stalls on load-use and on branch/jump operands that
//                forwarding cannot yet supply, flushes IF/ID on a taken
//                branch and freezes the pipe while a mul/div occupies EX.
//  Ports       : IF_ID_Rs/Rt, UsesRt, PCWriteCond, Jump, BranchTaken - ID
//                ID_EX_* / EX_MEM_*  - producers in EX and MEM
//                MduStart            - EX holds a mul/div op
//                PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
//                ID_EX_Bubble, EX_MEM_Bubble - pipeline register controls
//                StallCount          - saturating count of PC-hold cycles
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import pcpu_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             UsesRt,
  input  logic [3:0]       PCWriteCond,
  input  logic [1:0]       Jump,
  input  logic             BranchTaken,
  input  logic [4:0]       ID_EX_WriteReg,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_WriteReg,
  input  logic             EX_MEM_MemRead,
  input  logic             MduStart,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic [CNT_W-1:0] StallCount
);

  // Counter holds the MDU cycles remaining after the current one.
  localparam int             MC_W     = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [MC_W-1:0] MDU_INIT = MC_W'(MDU_LAT - 2);
  localparam logic [MC_W-1:0] MC_ONE   = MC_W'(1);

  state_e          state_q, state_d;
  logic [MC_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic rt_read, is_br, ex_match, mem_match;
  logic lu_hit, bex_hit, bmem_hit;
  logic stall, freeze, flush, hold;

  always_comb begin
    rt_read   = UsesRt | (PCWriteCond != 4'd0);
    is_br     = (PCWriteCond != 4'd0) | (Jump != 2'd0);
    ex_match  = reg_match(ID_EX_WriteReg,  IF_ID_Rs, IF_ID_Rt, rt_read);
    mem_match = reg_match(EX_MEM_WriteReg, IF_ID_Rs, IF_ID_Rt, rt_read);
    lu_hit    = ID_EX_MemRead & ex_match;
    bex_hit   = is_br & ID_EX_RegWrite & ex_match;
    bmem_hit  = is_br & EX_MEM_MemRead & mem_match;
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    stall     = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MduStart) begin
          freeze    = 1'b1;
          mdu_cnt_d = MDU_INIT;
          state_d   = ST_MDU;
        end else begin
          stall = lu_hit | bex_hit | bmem_hit;
          // A branch consuming a load result in EX needs the load to reach
          // WB before its operand is forwardable into ID: one extra stall.
          if (bex_hit && ID_EX_MemRead) begin
            state_d = ST_BSTALL;
          end
          flush = ~stall & BranchTaken;
        end
      end
      ST_BSTALL: begin
        stall   = 1'b1;
        state_d = ST_RUN;
      end
      ST_MDU: begin
        freeze = 1'b1;
        if (mdu_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          mdu_cnt_d = mdu_cnt_q - MC_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // While reset is held all controls sit at their free-running values.
  assign hold          = rst_n & (stall | freeze);
  assign PCWrite       = ~hold;
  assign IF_ID_Write   = ~hold;
  assign IF_ID_Flush   = rst_n & flush;
  assign ID_EX_Write   = ~(rst_n & freeze);
  assign ID_EX_Bubble  = rst_n & stall;
  assign EX_MEM_Bubble = rst_n & freeze;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PCWrite),
    .count (StallCount)
  );

endmodule
`default_nettype wire
